// File: rtl/quad_enc_gen.sv
// Quadrature A/B edge generator driven by (dir, count, interval) commands.
// Optional signed position counter enabled by QUAD_ENC_GEN_POS_EN.
module quad_enc_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 32
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic                    i_Dir,
  input  logic [CNT_W-1:0]        i_Count,
  input  logic [DIV_W-1:0]        i_Div,
  input  logic                    i_Abort,
  output logic                    o_A,
  output logic                    o_B,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic signed [POS_W-1:0] o_Pos
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] ivl_q;
  logic             a_q, b_q;
  logic             done_q;

  logic accept;
  logic step;
  logic finish;
  logic done_d;
  logic tog_a;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = i_Valid;
        if (i_Valid && (i_Count != '0)) state_d = RUN;
      end
      RUN: begin
        // Abort beats a due step: no edge on that cycle.
        if (i_Abort) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (ivl_q == '0) begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_d = finish || (accept && (i_Count == '0));

  // Gray step: forward toggles A when A==B, backward when A!=B.
  assign tog_a = dir_q ? (a_q == b_q) : (a_q != b_q);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      div_q  <= '0;
      ivl_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        dir_q <= i_Dir;
        cnt_q <= i_Count;
        div_q <= i_Div;
        ivl_q <= i_Div;
      end else if ((state_q == RUN) && !i_Abort) begin
        if (step) begin
          if (tog_a) a_q <= ~a_q;
          else       b_q <= ~b_q;
          cnt_q <= cnt_q - CNT_W'(1);
          ivl_q <= div_q;
        end else begin
          ivl_q <= ivl_q - DIV_W'(1);
        end
      end
    end
  end

`ifdef QUAD_ENC_GEN_POS_EN
  logic signed [POS_W-1:0] pos_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pos_q <= '0;
    end else if (step) begin
      if (dir_q) pos_q <= pos_q + POS_W'(1);
      else       pos_q <= pos_q - POS_W'(1);
    end
  end

  assign o_Pos = pos_q;
`else
  assign o_Pos = '0;
`endif

  assign o_Ready = (state_q == IDLE);
  assign o_Busy  = (state_q == RUN);
  assign o_A     = a_q;
  assign o_B     = b_q;
  assign o_Done  = done_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: expected A/B/done events queued per command.
// Position checks follow QUAD_ENC_GEN_POS_EN when it is defined.
module tb_quad_enc_gen;

`ifdef QUAD_ENC_GEN_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic               i_Clk;
  logic               i_Rst_n;
  logic               i_Valid;
  logic               o_Ready;
  logic               i_Dir;
  logic [15:0]        i_Count;
  logic [15:0]        i_Div;
  logic               i_Abort;
  logic               o_A;
  logic               o_B;
  logic               o_Busy;
  logic               o_Done;
  logic signed [31:0] o_Pos;

  quad_enc_gen dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .i_Dir  (i_Dir),
    .i_Count(i_Count),
    .i_Div  (i_Div),
    .i_Abort(i_Abort),
    .o_A    (o_A),
    .o_B    (o_B),
    .o_Busy (o_Busy),
    .o_Done (o_Done),
    .o_Pos  (o_Pos)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [7:0] cyc;
    logic [1:0] ab;
    logic       done;
  } ev_t;

  ev_t sb[$];
  ev_t obs[$];
  ev_t e, o;
  logic rdy[0:63];
  logic bsy[0:63];
  int tests = 0;
  int fails = 0;
  logic signed [31:0] exp_pos;

  function automatic ev_t mk(input int c, input logic [1:0] ab, input logic d);
    ev_t r;
    r.cyc  = 8'(c);
    r.ab   = ab;
    r.done = d;
    return r;
  endfunction

  task automatic apply_reset();
    i_Valid = 1'b0;
    i_Abort = 1'b0;
    i_Dir   = 1'b0;
    i_Count = '0;
    i_Div   = '0;
    i_Rst_n = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    @(negedge i_Clk);
  endtask

  task automatic send(input logic dir, input int cnt, input int div);
    i_Dir   = dir;
    i_Count = 16'(cnt);
    i_Div   = 16'(div);
    i_Valid = 1'b1;
  endtask

  // Records A/B changes and done pulses; k is clocks after the accept edge.
  task automatic observe(input int n, input int drop_at,
                         input int flip_at, input int abort_at);
    logic [1:0] prev;
    prev = {o_A, o_B};
    obs.delete();
    for (int k = 0; k <= n; k++) begin
      @(negedge i_Clk);
      rdy[k] = o_Ready;
      bsy[k] = o_Busy;
      if (({o_A, o_B} !== prev) || (o_Done === 1'b1))
        obs.push_back(mk(k, {o_A, o_B}, o_Done));
      prev = {o_A, o_B};
      if (k == drop_at) i_Valid = 1'b0;
      if (k == flip_at) i_Dir = 1'b0;
      i_Abort = (k == abort_at);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({o_A, o_B} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ab: got %b want 00", {o_A, o_B});
    end
    tests++;
    if ({o_Ready, o_Busy, o_Done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got rdy/busy/done=%b want 100",
               {o_Ready, o_Busy, o_Done});
    end
    tests++;
    if (o_Pos !== 32'sd0) begin
      fails++;
      $display("FAIL reset_pos: got %0d want 0", o_Pos);
    end
  endtask

  task automatic test_forward();
    apply_reset();
    send(1'b1, 4, 2);
    sb.push_back(mk(3, 2'b10, 1'b0));
    sb.push_back(mk(6, 2'b11, 1'b0));
    sb.push_back(mk(9, 2'b01, 1'b0));
    sb.push_back(mk(12, 2'b00, 1'b1));
    observe(16, 0, -1, -1);
    tests++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL fwd_nev: got %0d events want %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL fwd_ev: got cyc=%0d ab=%b done=%b want cyc=%0d ab=%b done=%b",
                 o.cyc, o.ab, o.done, e.cyc, e.ab, e.done);
      end
    end
    sb.delete();
    tests++;
    if (bsy[5] !== 1'b1 || rdy[5] !== 1'b0) begin
      fails++;
      $display("FAIL fwd_busy: got busy=%b rdy=%b want 1 0", bsy[5], rdy[5]);
    end
    exp_pos = POS_EN ? 32'sd4 : 32'sd0;
    tests++;
    if (o_Pos !== exp_pos) begin
      fails++;
      $display("FAIL fwd_pos: got %0d want %0d", o_Pos, exp_pos);
    end
  endtask

  task automatic test_backward();
    apply_reset();
    send(1'b0, 3, 0);
    sb.push_back(mk(1, 2'b01, 1'b0));
    sb.push_back(mk(2, 2'b11, 1'b0));
    sb.push_back(mk(3, 2'b10, 1'b1));
    observe(8, 0, -1, -1);
    tests++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL bwd_nev: got %0d events want %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL bwd_ev: got cyc=%0d ab=%b done=%b want cyc=%0d ab=%b done=%b",
                 o.cyc, o.ab, o.done, e.cyc, e.ab, e.done);
      end
    end
    sb.delete();
    exp_pos = POS_EN ? -32'sd3 : 32'sd0;
    tests++;
    if (o_Pos !== exp_pos) begin
      fails++;
      $display("FAIL bwd_pos: got %0d want %0d", o_Pos, exp_pos);
    end
  endtask

  task automatic test_zero_count();
    bit busy_seen;
    apply_reset();
    send(1'b1, 0, 3);
    sb.push_back(mk(0, 2'b00, 1'b1));
    observe(8, 0, -1, -1);
    tests++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL zero_nev: got %0d events want %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL zero_ev: got cyc=%0d ab=%b done=%b want cyc=%0d ab=%b done=%b",
                 o.cyc, o.ab, o.done, e.cyc, e.ab, e.done);
      end
    end
    sb.delete();
    busy_seen = 1'b0;
    for (int k = 0; k <= 8; k++) if (bsy[k] !== 1'b0) busy_seen = 1'b1;
    tests++;
    if (busy_seen) begin
      fails++;
      $display("FAIL zero_busy: got busy=1 want 0");
    end
  endtask

  task automatic test_abort();
    apply_reset();
    send(1'b1, 10, 1);
    sb.push_back(mk(2, 2'b10, 1'b0));
    sb.push_back(mk(4, 2'b11, 1'b0));
    sb.push_back(mk(6, 2'b01, 1'b0));
    sb.push_back(mk(8, 2'b01, 1'b1));
    observe(24, 0, -1, 7);
    tests++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL abort_nev: got %0d events want %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort_ev: got cyc=%0d ab=%b done=%b want cyc=%0d ab=%b done=%b",
                 o.cyc, o.ab, o.done, e.cyc, e.ab, e.done);
      end
    end
    sb.delete();
    tests++;
    if (rdy[8] !== 1'b1 || bsy[20] !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got rdy8=%b busy20=%b want 1 0", rdy[8], bsy[20]);
    end
    exp_pos = POS_EN ? 32'sd3 : 32'sd0;
    tests++;
    if (o_Pos !== exp_pos) begin
      fails++;
      $display("FAIL abort_pos: got %0d want %0d", o_Pos, exp_pos);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send(1'b1, 2, 0);
    sb.push_back(mk(1, 2'b10, 1'b0));
    sb.push_back(mk(2, 2'b11, 1'b1));
    sb.push_back(mk(4, 2'b10, 1'b0));
    sb.push_back(mk(5, 2'b00, 1'b1));
    observe(10, 3, 0, -1);
    tests++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL b2b_nev: got %0d events want %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_ev: got cyc=%0d ab=%b done=%b want cyc=%0d ab=%b done=%b",
                 o.cyc, o.ab, o.done, e.cyc, e.ab, e.done);
      end
    end
    sb.delete();
    tests++;
    if (rdy[2] !== 1'b1 || bsy[3] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap: got rdy2=%b busy3=%b want 1 1", rdy[2], bsy[3]);
    end
    tests++;
    if (o_Pos !== 32'sd0) begin
      fails++;
      $display("FAIL b2b_pos: got %0d want 0", o_Pos);
    end
  endtask

  task automatic test_reset_mid_run();
    bit bad;
    apply_reset();
    send(1'b1, 10, 0);
    observe(3, 0, -1, -1);
    #2 i_Rst_n = 1'b0;
    #1;
    tests++;
    if ({o_A, o_B, o_Ready, o_Busy, o_Done} !== 5'b00100) begin
      fails++;
      $display("FAIL rst_async: got ab/rdy/busy/done=%b want 00100",
               {o_A, o_B, o_Ready, o_Busy, o_Done});
    end
    tests++;
    if (o_Pos !== 32'sd0) begin
      fails++;
      $display("FAIL rst_pos: got %0d want 0", o_Pos);
    end
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_Clk);
      if (o_Done !== 1'b0 || {o_A, o_B} !== 2'b00 || o_Busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rst_quiet: got activity after reset want none");
    end
  endtask

  task automatic test_abort_idle();
    bit bad;
    apply_reset();
    bad = 1'b0;
    i_Abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_Clk);
      if (o_Done !== 1'b0 || o_Ready !== 1'b1) bad = 1'b1;
    end
    i_Abort = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_in_idle: got done or not ready want idle");
    end
  endtask

  initial begin
    i_Rst_n = 1'b0;
    i_Valid = 1'b0;
    i_Abort = 1'b0;
    i_Dir   = 1'b0;
    i_Count = '0;
    i_Div   = '0;
    test_reset();
    test_forward();
    test_backward();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_abort_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
